// File: rtl/afifo_rd_burst_ctrl_if.sv
// FIFO read port plus burst announcement and data stream between the
// read-side burst scheduler and its FIFO and consumer.
interface afifo_rd_burst_ctrl_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LVL_W  = 9,
  parameter int unsigned LEN_W  = 5
);
  logic              fifo_rd_en;
  logic              fifo_rd_empty;
  logic [LVL_W-1:0]  fifo_rd_water_level;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              burst_req;
  logic [LEN_W-1:0]  burst_len;
  logic              burst_ack;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              m_ready;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_empty, fifo_rd_water_level, fifo_rd_data,
    output burst_req, burst_len,
    input  burst_ack,
    output m_valid, m_data, m_last,
    input  m_ready
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_empty, fifo_rd_water_level, fifo_rd_data,
    input  burst_req, burst_len,
    output burst_ack,
    input  m_valid, m_data, m_last,
    output m_ready
  );
endinterface

// File: rtl/afifo_rd_burst_ctrl.sv
// Read-domain burst scheduler: drains the async FIFO in full bursts, flushes
// residue as a short burst on timeout or flush, streams through a 2-entry skid.
module afifo_rd_burst_ctrl #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned LVL_W     = 9,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned LEN_W     = 5,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned TO_W      = 8
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  enable,
  input  logic                  flush,
  afifo_rd_burst_ctrl_if.master bus,
  output logic                  busy,
  output logic [15:0]           burst_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} state_t;

  state_t            state;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  issued;
  logic [LEN_W-1:0]  out_cnt;
  logic [TO_W-1:0]   timer;
  logic [DATA_W-1:0] skid0;
  logic [DATA_W-1:0] skid1;
  logic [1:0]        occ;
  logic              inflight;

  logic [LVL_W-1:0]  lvl;
  logic              full_lvl;
  logic              partial;
  logic              pop;
  logic              rd_en_c;

  assign lvl      = bus.fifo_rd_water_level;
  assign full_lvl = lvl >= LVL_W'(BURST_LEN);
  assign partial  = (lvl != '0) && !full_lvl;
  assign pop      = (occ != 2'd0) && bus.m_ready;

  // Issue only while the skid can absorb every word already requested,
  // counting the head beat that leaves this cycle so a ready consumer sees 1 beat/cycle.
  assign rd_en_c = (state == XFER) && (issued < len) && !bus.fifo_rd_empty &&
                   ((3'(occ) + 3'(inflight)) < (3'd2 + 3'(pop)));

  assign bus.fifo_rd_en = rd_en_c;
  assign bus.burst_req  = (state == REQ);
  assign bus.burst_len  = len;
  assign bus.m_valid    = (occ != 2'd0);
  assign bus.m_data     = skid0;
  assign bus.m_last     = (occ != 2'd0) && (out_cnt == len - LEN_W'(1));
  assign busy           = (state != IDLE);

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state     <= IDLE;
      len       <= '0;
      issued    <= '0;
      out_cnt   <= '0;
      timer     <= '0;
      skid0     <= '0;
      skid1     <= '0;
      occ       <= 2'd0;
      inflight  <= 1'b0;
      burst_cnt <= 16'd0;
    end else begin
      inflight <= rd_en_c;
      if (rd_en_c) issued <= issued + LEN_W'(1);

      // Skid buffer: write the word requested last cycle, pop the head on a beat
      unique case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) skid0 <= bus.fifo_rd_data;
          else             skid1 <= bus.fifo_rd_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          skid0 <= skid1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            skid0 <= bus.fifo_rd_data;
          end else begin
            skid0 <= skid1;
            skid1 <= bus.fifo_rd_data;
          end
        end
        default: ;
      endcase

      unique case (state)
        IDLE: begin
          if (enable && full_lvl) begin
            len   <= LEN_W'(BURST_LEN);
            timer <= '0;
            state <= REQ;
          end else if (enable && partial && ((timer == TO_W'(TIMEOUT)) || flush)) begin
            len   <= LEN_W'(lvl);
            timer <= '0;
            state <= REQ;
          end else if (enable && partial) begin
            if (timer != TO_W'(TIMEOUT)) timer <= timer + TO_W'(1);
          end else begin
            timer <= '0;
          end
        end
        REQ: begin
          if (bus.burst_ack) begin
            issued  <= '0;
            out_cnt <= '0;
            state   <= XFER;
          end
        end
        XFER: begin
          if (pop) begin
            out_cnt <= out_cnt + LEN_W'(1);
            if (out_cnt == len - LEN_W'(1)) begin
              burst_cnt <= burst_cnt + 16'd1;
              state     <= GAP;
            end
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_afifo_rd_burst_ctrl.sv
// Directed bench for afifo_rd_burst_ctrl with a queue-based FIFO model.
module tb_afifo_rd_burst_ctrl;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        flush;
  logic        busy;
  logic [15:0] burst_cnt;

  afifo_rd_burst_ctrl_if #(.DATA_W(64), .LVL_W(9), .LEN_W(5)) bus ();

  afifo_rd_burst_ctrl #(
    .DATA_W(64), .LVL_W(9), .BURST_LEN(16), .LEN_W(5), .TIMEOUT(8), .TO_W(8)
  ) dut (
    .rd_clk    (clk),
    .rd_rst    (rst),
    .enable    (enable),
    .flush     (flush),
    .bus       (bus),
    .busy      (busy),
    .burst_cnt (burst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          nchk;
  int          nfail;
  logic [63:0] q[$];

  logic        s_req, s_valid, s_last, s_ren, s_ready, s_busy;
  logic [4:0]  s_len;
  logic [63:0] s_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic update_fifo();
    bus.fifo_rd_water_level = 9'(q.size());
    bus.fifo_rd_empty       = (q.size() == 0);
  endtask

  task automatic push(input int n, input int base);
    for (int i = 0; i < n; i++) q.push_back(64'(base + i));
    update_fifo();
  endtask

  // Sample one cycle at negedge, then let the FIFO model act on the edge.
  task automatic tick();
    @(negedge clk);
    s_req   = bus.burst_req;
    s_len   = bus.burst_len;
    s_valid = bus.m_valid;
    s_data  = bus.m_data;
    s_last  = bus.m_last;
    s_ren   = bus.fifo_rd_en;
    s_ready = bus.m_ready;
    s_busy  = busy;
    @(posedge clk);
    #1;
    if (s_ren && q.size() > 0) bus.fifo_rd_data = q.pop_front();
    update_fifo();
  endtask

  task automatic wait_req(input string tag, input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!s_req && n < budget);
    chk({tag, "_req_seen"}, 64'(s_req), 64'(1));
  endtask

  task automatic run_burst(input string tag, input int exp_len, input int base,
                           input int ack_dly, input bit bp, input int stop_after,
                           input bit flush_mid);
    int          beats, reads, k, first_k, last_k, target;
    logic        pv, pr, pl;
    logic [63:0] pd;
    bit          flushed;
    target = (stop_after > 0) ? stop_after : exp_len;
    chk({tag, "_len"}, 64'(s_len), 64'(exp_len));
    for (int i = 1; i < ack_dly; i++) begin
      tick();
      chk({tag, "_req_hold"}, 64'(s_req), 64'(1));
      chk({tag, "_len_hold"}, 64'(s_len), 64'(exp_len));
    end
    bus.burst_ack = 1'b1;
    tick();
    bus.burst_ack = 1'b0;
    chk({tag, "_req_at_ack"}, 64'(s_req), 64'(1));
    beats = 0; reads = 0; k = 0; first_k = -1; last_k = 0;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; flushed = 1'b0;
    while (beats < target && k < 400) begin
      bus.m_ready = bp ? (k % 2 == 0) : 1'b1;
      if (flush_mid && beats == 1 && !flushed) begin
        flush   = 1'b1;
        flushed = 1'b1;
      end
      tick();
      flush = 1'b0;
      k++;
      if (k == 1) chk({tag, "_first_rd_en"}, 64'(s_ren), 64'(1));
      if (s_ren) reads++;
      if (pv && !pr) begin
        chk({tag, "_hold_valid"}, 64'(s_valid), 64'(1));
        chk({tag, "_hold_data"}, s_data, pd);
        chk({tag, "_hold_last"}, 64'(s_last), 64'(pl));
      end
      if (s_valid && s_ready) begin
        chk({tag, "_data"}, s_data, 64'(base + beats));
        chk({tag, "_last"}, 64'(s_last), 64'(beats == exp_len - 1));
        if (first_k < 0) first_k = k;
        last_k = k;
        beats++;
      end
      chk({tag, "_outstanding"}, 64'((reads - beats) <= 2), 64'(1));
      pv = s_valid; pr = s_ready; pd = s_data; pl = s_last;
    end
    chk({tag, "_beats"}, 64'(beats), 64'(target));
    if (stop_after == 0) begin
      if (!bp) chk({tag, "_consecutive"}, 64'(last_k - first_k), 64'(exp_len - 1));
      tick();
      chk({tag, "_gap_busy"}, 64'(s_busy), 64'(1));
      if (s_ren) reads++;
      tick();
      chk({tag, "_idle_busy"}, 64'(s_busy), 64'(0));
      if (s_ren) reads++;
      chk({tag, "_reads"}, 64'(reads), 64'(exp_len));
    end
  endtask

  initial begin
    int n;
    nchk  = 0;
    nfail = 0;
    rst = 1'b1; enable = 1'b0; flush = 1'b0;
    bus.burst_ack = 1'b0; bus.m_ready = 1'b1; bus.fifo_rd_data = '0;
    update_fifo();
    #1;
    chk("rst_rd_en",  64'(bus.fifo_rd_en), 64'(0));
    chk("rst_req",    64'(bus.burst_req), 64'(0));
    chk("rst_len",    64'(bus.burst_len), 64'(0));
    chk("rst_valid",  64'(bus.m_valid), 64'(0));
    chk("rst_data",   bus.m_data, 64'(0));
    chk("rst_last",   64'(bus.m_last), 64'(0));
    chk("rst_busy",   64'(busy), 64'(0));
    chk("rst_cnt",    64'(burst_cnt), 64'(0));
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Full burst, ack two cycles after request
    push(16, 0);
    enable = 1'b1;
    wait_req("full", 20, n);
    chk("full_req_latency", 64'(n), 64'(2));
    run_burst("full", 16, 0, 2, 1'b0, 0, 1'b0);
    chk("full_cnt", 64'(burst_cnt), 64'(1));

    // Timeout short burst
    push(5, 50);
    wait_req("tmo", 40, n);
    chk("tmo_req_latency", 64'(n), 64'(10));
    run_burst("tmo", 5, 50, 1, 1'b0, 0, 1'b0);
    chk("tmo_cnt", 64'(burst_cnt), 64'(2));

    // Backpressure 1,0,1,0
    push(16, 80);
    wait_req("bp", 20, n);
    chk("bp_req_latency", 64'(n), 64'(2));
    run_burst("bp", 16, 80, 1, 1'b1, 0, 1'b0);
    bus.m_ready = 1'b1;
    chk("bp_cnt", 64'(burst_cnt), 64'(3));

    // Flush, with a second flush during XFER that must be forgotten
    push(3, 200);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_req("flush", 20, n);
    chk("flush_req_latency", 64'(n), 64'(1));
    push(2, 203);
    run_burst("flush", 3, 200, 1, 1'b0, 0, 1'b1);
    wait_req("flush_rest", 40, n);
    chk("flush_not_remembered", 64'(n), 64'(9));
    run_burst("flush_rest", 2, 203, 1, 1'b0, 0, 1'b0);
    chk("flush_cnt", 64'(burst_cnt), 64'(5));

    // Back-to-back from a 40-word preload
    enable = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("b2b_cnt_cleared", 64'(burst_cnt), 64'(0));
    push(40, 100);
    enable = 1'b1;
    wait_req("b2b1", 20, n);
    chk("b2b1_req_latency", 64'(n), 64'(2));
    run_burst("b2b1", 16, 100, 1, 1'b0, 0, 1'b0);
    wait_req("b2b2", 20, n);
    chk("b2b2_req_latency", 64'(n), 64'(1));
    run_burst("b2b2", 16, 116, 1, 1'b0, 0, 1'b0);
    wait_req("b2b3", 40, n);
    chk("b2b3_req_latency", 64'(n), 64'(9));
    run_burst("b2b3", 8, 132, 1, 1'b0, 0, 1'b0);
    chk("b2b_cnt", 64'(burst_cnt), 64'(3));

    // Reset after 7 beats of a full burst
    push(16, 300);
    wait_req("mid", 20, n);
    run_burst("mid", 16, 300, 1, 1'b0, 7, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_rd_en", 64'(bus.fifo_rd_en), 64'(0));
    chk("mid_rst_req",   64'(bus.burst_req), 64'(0));
    chk("mid_rst_valid", 64'(bus.m_valid), 64'(0));
    chk("mid_rst_data",  bus.m_data, 64'(0));
    chk("mid_rst_last",  64'(bus.m_last), 64'(0));
    chk("mid_rst_busy",  64'(busy), 64'(0));
    chk("mid_rst_cnt",   64'(burst_cnt), 64'(0));
    q.delete();
    bus.fifo_rd_data = '0;
    update_fifo();
    tick();
    rst = 1'b0;
    enable = 1'b0;
    repeat (2) tick();
    chk("post_rst_busy",  64'(s_busy), 64'(0));
    chk("post_rst_req",   64'(s_req), 64'(0));
    chk("post_rst_valid", 64'(s_valid), 64'(0));
    chk("post_rst_cnt",   64'(burst_cnt), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
